// File: rtl/spi_xfer_sequencer_if.sv
// Wishbone master bus between spi_xfer_sequencer and the spi_top slave port.
// Signals: adr/dat/sel/we/stb/cyc (master out), dat_i/ack_i/int_i (slave out).
interface spi_xfer_sequencer_if;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_int_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_int_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_int_i
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Two-port round-robin Wishbone master that runs one spi_top transfer per
// request: CTRL, DIVIDER, SS, TX0, GO, wait for completion, read RX0, respond.
// Ports: wb_clk_in/wb_rst_in (sync, active-high), req_* (per-port request,
//   valid/ready), cfg_div_i/cfg_mode_i (sampled at accept), resp_* (one-cycle
//   one-hot response), wb (Wishbone master modport incl. ack and interrupt).
// Option: define SPI_SEQ_POLL_EN to poll GO_BSY instead of using wb_int_i.
module spi_xfer_sequencer #(
    parameter int SS_NB       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 wb_clk_in,
    input  logic                 wb_rst_in,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [31:0]          req_data0_i,
    input  logic [31:0]          req_data1_i,
    input  logic [SS_NB-1:0]     req_ss0_i,
    input  logic [SS_NB-1:0]     req_ss1_i,
    input  logic [6:0]           req_len0_i,
    input  logic [6:0]           req_len1_i,
    input  logic [15:0]          cfg_div_i,
    input  logic [2:0]           cfg_mode_i,
    output logic [1:0]           resp_valid_o,
    output logic [31:0]          resp_data_o,
    output logic                 resp_err_o,
    spi_xfer_sequencer_if.master wb
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

`ifdef SPI_SEQ_POLL_EN
    localparam logic IE_BIT = 1'b0;
    logic unused_int;
    assign unused_int = wb.wb_int_i;
`else
    localparam logic IE_BIT = 1'b1;
`endif

    typedef enum logic [3:0] {
        IDLE, WR_CTRL, WR_DIV, WR_SS, WR_TX,
        WR_GO, WAIT_DONE, RD_RX, RESP
    } state_e;

    state_e           state_q, state_d;
    logic             gap_q, gap_d;
    logic             grant_q;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      rx_q, rx_d;
    logic             err_q, err_d;
    logic [31:0]      data_q;
    logic [SS_NB-1:0] ss_q;
    logic [6:0]       len_q;
    logic [15:0]      div_q;
    logic [2:0]       mode_q;

    logic             gsel;
    logic             accept;
    logic             bus_act;
    logic             ack;
    logic             done;
    logic [31:0]      ctrl_w;

    // CTRL with GO=0; the GO write ORs in bit 8.
    assign ctrl_w = {18'b0, 1'b1, IE_BIT, mode_q, 1'b0, 1'b0, len_q};

    // Both requesting: serve the port that did not win last time.
    always_comb begin
        gsel   = (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];
        accept = (state_q == IDLE) && !wb_rst_in && (req_valid_i != 2'b00);
    end

    // gap_q marks the mandatory idle bus cycle between back-to-back accesses.
    always_comb begin
        unique case (state_q)
            WR_CTRL, WR_DIV, WR_SS,
            WR_TX, WR_GO, RD_RX:  bus_act = !gap_q;
`ifdef SPI_SEQ_POLL_EN
            WAIT_DONE:            bus_act = !gap_q;
`endif
            default:              bus_act = 1'b0;
        endcase
    end

    assign ack = bus_act && wb.wb_ack_i;

    always_ff @(posedge wb_clk_in) begin
        if (wb_rst_in) begin
            state_q <= IDLE;
            gap_q   <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            ss_q    <= '0;
            len_q   <= '0;
            div_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            if (accept) begin
                grant_q <= gsel;
                data_q  <= gsel ? req_data1_i : req_data0_i;
                ss_q    <= gsel ? req_ss1_i : req_ss0_i;
                len_q   <= gsel ? req_len1_i : req_len0_i;
                div_q   <= cfg_div_i;
                mode_q  <= cfg_mode_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        last_d  = last_q;
        cnt_d   = '0;
        rx_d    = rx_q;
        err_d   = err_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WR_CTRL;
                    gap_d   = 1'b0;
                    err_d   = 1'b0;
                    rx_d    = '0;
                end
            end
            WR_CTRL, WR_DIV, WR_SS, WR_TX, WR_GO: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (ack) begin
                    gap_d = 1'b1;
                    unique case (state_q)
                        WR_CTRL: state_d = WR_DIV;
                        WR_DIV:  state_d = WR_SS;
                        WR_SS:   state_d = WR_TX;
                        WR_TX:   state_d = WR_GO;
                        default: state_d = WAIT_DONE;
                    endcase
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
`ifdef SPI_SEQ_POLL_EN
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (ack) begin
                    gap_d = 1'b1;
                    done  = !wb.wb_dat_i[8];
                end
`else
                done = wb.wb_int_i;
`endif
                // Completion seen on the last counted cycle still wins.
                if (done) begin
                    state_d = RD_RX;
                    cnt_d   = '0;
`ifdef SPI_SEQ_POLL_EN
                    gap_d   = 1'b1;
`else
                    gap_d   = 1'b0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    gap_d   = 1'b0;
                    err_d   = 1'b1;
                    rx_d    = '0;
                    cnt_d   = '0;
                end
            end
            RD_RX: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (ack) begin
                    rx_d    = wb.wb_dat_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb.wb_cyc_o = bus_act;
        wb.wb_stb_o = bus_act;
        wb.wb_sel_o = bus_act ? 4'hF : 4'h0;
        wb.wb_we_o  = 1'b0;
        wb.wb_adr_o = 5'h00;
        wb.wb_dat_o = 32'h0;
        if (bus_act) begin
            unique case (state_q)
                WR_CTRL: begin
                    wb.wb_we_o  = 1'b1;
                    wb.wb_adr_o = 5'h10;
                    wb.wb_dat_o = ctrl_w;
                end
                WR_DIV: begin
                    wb.wb_we_o  = 1'b1;
                    wb.wb_adr_o = 5'h14;
                    wb.wb_dat_o = {16'b0, div_q};
                end
                WR_SS: begin
                    wb.wb_we_o  = 1'b1;
                    wb.wb_adr_o = 5'h18;
                    wb.wb_dat_o = 32'(ss_q);
                end
                WR_TX: begin
                    wb.wb_we_o  = 1'b1;
                    wb.wb_adr_o = 5'h00;
                    wb.wb_dat_o = data_q;
                end
                WR_GO: begin
                    wb.wb_we_o  = 1'b1;
                    wb.wb_adr_o = 5'h10;
                    wb.wb_dat_o = ctrl_w | 32'h100;
                end
                WAIT_DONE: wb.wb_adr_o = 5'h10;
                RD_RX:     wb.wb_adr_o = 5'h00;
                default:   wb.wb_adr_o = 5'h00;
            endcase
        end
        req_ready_o  = accept ? (gsel ? 2'b10 : 2'b01) : 2'b00;
        resp_valid_o = 2'b00;
        resp_data_o  = 32'h0;
        resp_err_o   = 1'b0;
        if (state_q == RESP) begin
            resp_valid_o = grant_q ? 2'b10 : 2'b01;
            resp_data_o  = rx_q;
            resp_err_o   = err_q;
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a small spi_top bus model
// (one-cycle registered ack, RX loopback, interrupt or GO_BSY polling).
module tb_spi_xfer_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  req_valid, req_ready, resp_valid;
    logic [31:0] d0, d1, resp_data;
    logic [7:0]  ss0, ss1;
    logic [6:0]  l0, l1;
    logic [15:0] div;
    logic [2:0]  mode;
    logic        resp_err;

    spi_xfer_sequencer_if bus();

    spi_xfer_sequencer dut (
        .wb_clk_in    (clk),
        .wb_rst_in    (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_data0_i  (d0),
        .req_data1_i  (d1),
        .req_ss0_i    (ss0),
        .req_ss1_i    (ss1),
        .req_len0_i   (l0),
        .req_len1_i   (l1),
        .cfg_div_i    (div),
        .cfg_mode_i   (mode),
        .resp_valid_o (resp_valid),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .wb           (bus)
    );

`ifdef SPI_SEQ_POLL_EN
    localparam logic [31:0] C1A = 32'h2A04, C1B = 32'h2B04;
    localparam logic [31:0] C3A = 32'h2008, C3B = 32'h2108;
`else
    localparam logic [31:0] C1A = 32'h3A04, C1B = 32'h3B04;
    localparam logic [31:0] C3A = 32'h3008, C3B = 32'h3108;
`endif

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // bus model
    logic        s_ack = 1'b0;
    logic [31:0] s_dat = 32'h0;
    logic        s_int = 1'b0;
    logic [31:0] loop_q = 32'h0;
    int          int_cnt = -1;
    int          poll_left = 0;
    bit          int_en = 1'b1;
    bit          poll_hang = 1'b0;
    int          poll_cfg = 0;
    logic [31:0] wadr_a [0:1023];
    logic [31:0] wdat_a [0:1023];
    logic [4:0]  radr_a [0:1023];
    int          wn = 0;
    int          rn = 0;
    int          cyc_n = 0;
    int          go_cyc = 0;

    assign bus.wb_ack_i = s_ack;
    assign bus.wb_dat_i = s_dat;
    assign bus.wb_int_i = s_int;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        s_ack <= 1'b0;
        s_int <= 1'b0;
        if (int_cnt > 0) int_cnt <= int_cnt - 1;
        else if (int_cnt == 0) begin
            s_int   <= int_en;
            int_cnt <= -1;
        end
        if (bus.wb_cyc_o && bus.wb_stb_o && !s_ack) begin
            s_ack <= 1'b1;
            if (bus.wb_we_o) begin
                wadr_a[wn] <= 32'(bus.wb_adr_o);
                wdat_a[wn] <= bus.wb_dat_o;
                wn <= wn + 1;
                if (bus.wb_adr_o == 5'h00) loop_q <= bus.wb_dat_o;
                if (bus.wb_adr_o == 5'h10 && bus.wb_dat_o[8]) begin
                    int_cnt   <= 4;
                    poll_left <= poll_cfg;
                end
            end else begin
                radr_a[rn] <= bus.wb_adr_o;
                rn <= rn + 1;
                if (bus.wb_adr_o == 5'h10) begin
                    s_dat <= {23'b0, (poll_hang || poll_left > 0), 8'b0};
                    if (poll_left > 0) poll_left <= poll_left - 1;
                end else begin
                    s_dat <= loop_q;
                end
            end
        end
    end

    // bus protocol monitor
    bit prev_ack = 1'b0;
    always @(negedge clk) begin
        if (prev_ack && !rst) chk("gap_idle", 32'(bus.wb_cyc_o), 32'h0);
        if (bus.wb_cyc_o) chk("sel", 32'(bus.wb_sel_o), 32'hF);
        prev_ack = bus.wb_cyc_o && bus.wb_stb_o && s_ack;
        if (prev_ack && bus.wb_we_o && bus.wb_adr_o == 5'h10 && bus.wb_dat_o[8])
            go_cyc = cyc_n;
    end

    function automatic int nreads(input int from, input logic [4:0] a);
        int c = 0;
        for (int i = from; i < rn; i++) if (radr_a[i] == a) c++;
        return c;
    endfunction

    task automatic wait_ready(input string tag, input logic [1:0] exp);
        int i = 0;
        #1;
        while (req_ready == 2'b00 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(req_ready), 32'(exp));
        @(posedge clk);
        #1;
        req_valid = req_valid & ~exp;
    endtask

    int resp_cyc = 0;
    task automatic wait_resp(output logic [1:0] v, output logic [31:0] d, output logic e);
        int i = 0;
        @(negedge clk);
        while (resp_valid == 2'b00 && i < 6000) begin
            @(negedge clk);
            i++;
        end
        if (resp_valid == 2'b00) begin
            n_chk++;
            n_err++;
            $error("FAIL resp_wait: observed no response expected a pulse");
        end
        v = resp_valid;
        d = resp_data;
        e = resp_err;
        resp_cyc = cyc_n;
    endtask

    logic [31:0] exp_a [0:4];
    logic [31:0] exp_d [0:4];

    initial begin
        logic [1:0]  v;
        logic [31:0] d;
        logic        e;
        int          wb0, rb0, i;

        rst = 1'b1;
        req_valid = 2'b00;
        d0 = '0; d1 = '0; ss0 = '0; ss1 = '0;
        l0 = '0; l1 = '0; div = '0; mode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(bus.wb_cyc_o), 0);
        chk("rst_stb", 32'(bus.wb_stb_o), 0);
        chk("rst_we", 32'(bus.wb_we_o), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rvalid", 32'(resp_valid), 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_rerr", 32'(resp_err), 0);
        rst = 1'b0;

        // 1: single port0 transfer, full register sequence
        d0 = 32'h236f; l0 = 7'd4; ss0 = 8'h01; div = 16'd4; mode = 3'b101;
        wb0 = wn; rb0 = rn;
        req_valid = 2'b01;
        wait_ready("t1_ready", 2'b01);
        div = 16'hFFFF; mode = 3'b010;
        wait_resp(v, d, e);
        chk("t1_rvalid", 32'(v), 32'h1);
        chk("t1_rdata", d, 32'h236f);
        chk("t1_rerr", 32'(e), 0);
        exp_a[0] = 32'h10; exp_d[0] = C1A;
        exp_a[1] = 32'h14; exp_d[1] = 32'h4;
        exp_a[2] = 32'h18; exp_d[2] = 32'h1;
        exp_a[3] = 32'h00; exp_d[3] = 32'h236f;
        exp_a[4] = 32'h10; exp_d[4] = C1B;
        chk("t1_nwr", 32'(wn - wb0), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t1_wadr%0d", k), wadr_a[wb0 + k], exp_a[k]);
            chk($sformatf("t1_wdat%0d", k), wdat_a[wb0 + k], exp_d[k]);
        end
        chk("t1_rx_reads", 32'(nreads(rb0, 5'h00)), 1);
        chk("t1_last_rd", 32'(radr_a[rn - 1]), 0);
        div = 16'd4; mode = 3'b101;

        // 2: round robin after reset, order 0,1,0,1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d0 = 32'hA0A0_0001; d1 = 32'hB1B1_0002;
        for (int r = 0; r < 2; r++) begin
            req_valid = 2'b11;
            for (int k = 0; k < 2; k++) begin
                wait_ready($sformatf("t2_ready_r%0d_%0d", r, k), (k == 0) ? 2'b01 : 2'b10);
                wait_resp(v, d, e);
                chk($sformatf("t2_rvalid_r%0d_%0d", r, k), 32'(v), (k == 0) ? 32'h1 : 32'h2);
                chk($sformatf("t2_rdata_r%0d_%0d", r, k), d, (k == 0) ? d0 : d1);
                if (k == 0) chk("t2_ready_in_resp", 32'(req_ready), 0);
            end
        end

        // 3: port1 alone, mode 000 len 8
        d1 = 32'h0000_C3C3; l1 = 7'd8; ss1 = 8'h80; mode = 3'b000; div = 16'h0102;
        wb0 = wn;
        req_valid = 2'b10;
        wait_ready("t3_ready", 2'b10);
        wait_resp(v, d, e);
        chk("t3_rvalid", 32'(v), 32'h2);
        chk("t3_rdata", d, 32'h0000_C3C3);
        chk("t3_ctrl", wdat_a[wb0], C3A);
        chk("t3_div", wdat_a[wb0 + 1], 32'h0102);
        chk("t3_ss", wdat_a[wb0 + 2], 32'h80);
        chk("t3_go", wdat_a[wb0 + 4], C3B);

        // 4: completion never signalled -> timeout response
        int_en = 1'b0; poll_hang = 1'b1;
        rb0 = rn;
        d0 = 32'h1234_5678;
        req_valid = 2'b01;
        wait_ready("t4_ready", 2'b01);
        wait_resp(v, d, e);
        chk("t4_rvalid", 32'(v), 32'h1);
        chk("t4_rerr", 32'(e), 1);
        chk("t4_rdata", d, 0);
        chk("t4_latency", 32'(resp_cyc - go_cyc), 32'd4097);
        chk("t4_no_rx", 32'(nreads(rb0, 5'h00)), 0);
        @(negedge clk);
        chk("t4_idle_cyc", 32'(bus.wb_cyc_o), 0);
        chk("t4_rvalid_off", 32'(resp_valid), 0);
        int_en = 1'b1; poll_hang = 1'b0;

        // 5: reset while WR_TX strobes
        d0 = 32'h5555_AAAA; d1 = 32'h0F0F_0F0F;
        req_valid = 2'b01;
        wait_ready("t5_ready", 2'b01);
        i = 0;
        @(negedge clk);
        while (!(bus.wb_stb_o && bus.wb_we_o && bus.wb_adr_o == 5'h00) && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("t5_in_wrtx", 32'(bus.wb_stb_o), 1);
        rst = 1'b1;
        req_valid = 2'b10;
        @(posedge clk);
        #1;
        chk("t5_cyc", 32'(bus.wb_cyc_o), 0);
        chk("t5_stb", 32'(bus.wb_stb_o), 0);
        chk("t5_rvalid", 32'(resp_valid), 0);
        chk("t5_ready_in_rst", 32'(req_ready), 0);
        @(negedge clk);
        chk("t5_rvalid2", 32'(resp_valid), 0);
        rst = 1'b0;
        wait_ready("t5_idle_ready", 2'b10);
        wait_resp(v, d, e);
        chk("t5_after_rvalid", 32'(v), 32'h2);
        chk("t5_after_rdata", d, 32'h0F0F_0F0F);

`ifdef SPI_SEQ_POLL_EN
        // 6: GO_BSY reads 1,1,0
        poll_cfg = 2;
        rb0 = rn;
        d0 = 32'h0000_6666;
        req_valid = 2'b01;
        wait_ready("t6_ready", 2'b01);
        wait_resp(v, d, e);
        chk("t6_rvalid", 32'(v), 32'h1);
        chk("t6_rdata", d, 32'h0000_6666);
        chk("t6_rerr", 32'(e), 0);
        chk("t6_polls", 32'(nreads(rb0, 5'h10)), 3);
        chk("t6_last_rd", 32'(radr_a[rn - 1]), 0);
        poll_cfg = 0;
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
